// File: rtl/muxn_arb.sv
// N-channel, W-bit registered mux with valid/ready handshake, select or round-robin grant.
// Optional burst lock is compiled in with `define MUXN_LOCK_EN (iLAST is ignored otherwise).
module muxn_arb #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iMODE,
    input  logic [SELW-1:0]   iSEL,
    input  logic [N*W-1:0]    iDATA,
    input  logic [N-1:0]      iVALID,
    input  logic [N-1:0]      iLAST,
    output logic [N-1:0]      oREADY,
    output logic [W-1:0]      oDATA,
    output logic              oVALID,
    output logic [SELW-1:0]   oCH,
    input  logic              iREADY
);

    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;

    logic            sel_vld_s, rr_vld_s, grant_vld_s;
    logic [SELW-1:0] sel_idx_s, rr_idx_s, grant_idx_s;
    logic            rr_hit_s;
    logic [W-1:0]    data_sel_s;
    logic            last_sel_s;
    logic            load_en_s;
    logic            xfer_s;

`ifdef MUXN_LOCK_EN
    logic            lock_q, lock_d;
`else
    logic            unused_last_s;
    assign unused_last_s = ^iLAST;
`endif

    // Candidate grants for both modes; rr walks from farthest to nearest so the nearest valid wins.
    always_comb begin
        sel_vld_s = 1'b0;
        sel_idx_s = {SELW{1'b0}};
        rr_vld_s  = 1'b0;
        rr_idx_s  = {SELW{1'b0}};
        rr_hit_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            sel_vld_s = sel_vld_s | ((iSEL == SELW'(k)) && iVALID[k]);
            sel_idx_s = ((iSEL == SELW'(k)) && iVALID[k]) ? SELW'(k) : sel_idx_s;
        end
        for (int off = N; off >= 1; off--) begin
            for (int k = 0; k < N; k++) begin
                rr_hit_s = iVALID[k] && (((int'(ptr_q) + off) % N) == k);
                rr_vld_s = rr_vld_s | rr_hit_s;
                rr_idx_s = rr_hit_s ? SELW'(k) : rr_idx_s;
            end
        end
    end

    // Final grant: a held burst lock overrides both modes and waits on the locked channel.
    always_comb begin
        grant_vld_s = iMODE ? rr_vld_s : sel_vld_s;
        grant_idx_s = iMODE ? rr_idx_s : sel_idx_s;
`ifdef MUXN_LOCK_EN
        if (lock_q) begin
            grant_idx_s = ptr_q;
            grant_vld_s = 1'b0;
            for (int k = 0; k < N; k++) begin
                grant_vld_s = grant_vld_s | ((ptr_q == SELW'(k)) && iVALID[k]);
            end
        end else begin
            grant_idx_s = grant_idx_s;
        end
`endif
    end

    // Data/last of the granted channel and per-channel ready.
    always_comb begin
        data_sel_s = {W{1'b0}};
        last_sel_s = 1'b0;
        oREADY     = {N{1'b0}};
        load_en_s  = !valid_q || iREADY;
        xfer_s     = load_en_s && grant_vld_s;
        for (int k = 0; k < N; k++) begin
            data_sel_s = (grant_idx_s == SELW'(k)) ? iDATA[k*W +: W] : data_sel_s;
            last_sel_s = (grant_idx_s == SELW'(k)) ? iLAST[k] : last_sel_s;
            oREADY[k]  = iRSTn && xfer_s && (grant_idx_s == SELW'(k));
        end
    end

    // Output register next-state: load on transfer, empty on drain with no grant.
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef MUXN_LOCK_EN
        lock_d  = lock_q;
`endif
        if (xfer_s) begin
            data_d  = data_sel_s;
            ch_d    = grant_idx_s;
            valid_d = 1'b1;
            ptr_d   = grant_idx_s;
`ifdef MUXN_LOCK_EN
            lock_d  = !last_sel_s;
`endif
        end else if (load_en_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; ptr resets to N-1 so channel 0 wins the first round-robin grant.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            data_q  <= {W{1'b0}};
            ch_q    <= {SELW{1'b0}};
            valid_q <= 1'b0;
            ptr_q   <= SELW'(N - 1);
`ifdef MUXN_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef MUXN_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign oDATA  = data_q;
    assign oCH    = ch_q;
    assign oVALID = valid_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb (N=4, W=8): directed vectors, monitor pops on output transfers.
module tb_muxn_arb;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            iCLK;
    logic            iRSTn;
    logic            iMODE;
    logic [SELW-1:0] iSEL;
    logic [N*W-1:0]  iDATA;
    logic [N-1:0]    iVALID;
    logic [N-1:0]    iLAST;
    logic [N-1:0]    oREADY;
    logic [W-1:0]    oDATA;
    logic            oVALID;
    logic [SELW-1:0] oCH;
    logic            iREADY;

    int n_cmp = 0;
    int n_err = 0;
    logic [SELW+W-1:0] exp_q[$];

    muxn_arb #(.W(W), .N(N)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iMODE(iMODE), .iSEL(iSEL),
        .iDATA(iDATA), .iVALID(iVALID), .iLAST(iLAST), .oREADY(oREADY),
        .oDATA(oDATA), .oVALID(oVALID), .oCH(oCH), .iREADY(iREADY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic [SELW-1:0] c);
        exp_q.push_back({c, d});
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected beat.
    always @(negedge iCLK) begin
        if (iRSTn && oVALID && iREADY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got ch %0d data %0h, expected none", oCH, oDATA);
            end else begin
                logic [SELW+W-1:0] e;
                e = exp_q.pop_front();
                chk("beat", {22'd0, oCH, oDATA}, {22'd0, e});
            end
        end
    end

    initial begin
        logic [W-1:0] chdat [N];
        int rr_a [8];
        int rr_b [4];
        int lk [4];
        chdat[0] = 8'hAA; chdat[1] = 8'hBB; chdat[2] = 8'hCC; chdat[3] = 8'hDD;
        rr_b = '{1, 3, 1, 3};
`ifdef MUXN_LOCK_EN
        lk = '{1, 1, 1, 2};
`else
        lk = '{1, 2, 1, 2};
`endif

        iRSTn  = 1'b0;
        iMODE  = 1'b1;
        iSEL   = 2'd0;
        iDATA  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        iVALID = 4'b1111;
        iLAST  = 4'b0000;
        iREADY = 1'b1;

        // Reset state with all channels valid
        step(); step();
        @(negedge iCLK);
        chk("rst_ovalid", {31'd0, oVALID}, 32'd0);
        chk("rst_odata", {24'd0, oDATA}, 32'd0);
        chk("rst_och", {30'd0, oCH}, 32'd0);
        chk("rst_oready", {28'd0, oREADY}, 32'd0);
        step();
        iRSTn = 1'b1;

        // Round robin, all valid: 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) begin
            @(negedge iCLK);
            chk("rr_all_oready", {28'd0, oREADY}, 32'd1 << (i % 4));
            push(chdat[i % 4], SELW'(i % 4));
            step();
        end

        // Round robin, channels 1 and 3 only
        iVALID = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            chk("rr_13_oready", {28'd0, oREADY}, 32'd1 << rr_b[i]);
            push(chdat[rr_b[i]], SELW'(rr_b[i]));
            step();
        end

        // Select mode, iSEL=2
        iMODE  = 1'b0;
        iSEL   = 2'd2;
        iVALID = 4'b1111;
        @(negedge iCLK);
        chk("sel2_oready", {28'd0, oREADY}, 32'h4);
        push(8'hCC, 2'd2);
        step();
        // iSEL=3 not valid: no grant, output empties
        iSEL   = 2'd3;
        iVALID = 4'b0111;
        @(negedge iCLK);
        chk("sel3_oready", {28'd0, oREADY}, 32'd0);
        step();
        @(negedge iCLK);
        chk("sel3_ovalid", {31'd0, oVALID}, 32'd0);
        chk("sel3_odata_hold", {24'd0, oDATA}, 32'hCC);
        chk("sel3_och_hold", {30'd0, oCH}, 32'd2);
        step();

        // Backpressure: 0x5A held for 5 cycles
        iDATA[7:0] = 8'h5A;
        iSEL   = 2'd0;
        iVALID = 4'b0001;
        iREADY = 1'b0;
        @(negedge iCLK);
        chk("bp_load_oready", {28'd0, oREADY}, 32'h1);
        push(8'h5A, 2'd0);
        step();
        iDATA[7:0] = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            chk("bp_hold_odata", {24'd0, oDATA}, 32'h5A);
            chk("bp_hold_ovalid", {31'd0, oVALID}, 32'd1);
            chk("bp_hold_oready", {28'd0, oREADY}, 32'd0);
            step();
        end
        iREADY = 1'b1;
        @(negedge iCLK);
        chk("bp_release_oready", {28'd0, oREADY}, 32'h1);
        push(8'h11, 2'd0);
        step();

        // Mode switch while a round-robin beat is held
        iMODE  = 1'b1;
        iVALID = 4'b0100;
        @(negedge iCLK);
        chk("ms_rr_oready", {28'd0, oREADY}, 32'h4);
        push(8'hCC, 2'd2);
        step();
        iREADY = 1'b0;
        iMODE  = 1'b0;
        iSEL   = 2'd3;
        iVALID = 4'b1111;
        @(negedge iCLK);
        chk("ms_hold_oready", {28'd0, oREADY}, 32'd0);
        chk("ms_hold_odata", {24'd0, oDATA}, 32'hCC);
        step();
        iREADY = 1'b1;
        @(negedge iCLK);
        chk("ms_sel_oready", {28'd0, oREADY}, 32'h8);
        push(8'hDD, 2'd3);
        step();

        // Burst: channel 1 sends last=0,0,1 while channel 2 is valid
        iMODE  = 1'b1;
        iVALID = 4'b0110;
        for (int j = 0; j < 4; j++) begin
            iLAST = (j == 2) ? 4'b0010 : 4'b0000;
            @(negedge iCLK);
            chk("burst_oready", {28'd0, oREADY}, 32'd1 << lk[j]);
            push(chdat[lk[j]], SELW'(lk[j]));
            step();
        end
        iVALID = 4'b0000;
        iLAST  = 4'b0000;

        // Drain with a bounded wait
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() != 0) step();
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-operation discards a held beat
        iREADY = 1'b0;
        iVALID = 4'b0001;
        step();
        chk("mid_held_ovalid", {31'd0, oVALID}, 32'd1);
        iRSTn = 1'b0;
        #1;
        chk("mid_rst_ovalid", {31'd0, oVALID}, 32'd0);
        chk("mid_rst_odata", {24'd0, oDATA}, 32'd0);
        chk("mid_rst_oready", {28'd0, oREADY}, 32'd0);
        step();
        iRSTn = 1'b1;
        iVALID = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
